bist_scheduler: RTL

Sequences the pulse-generator BIST controller across up to NUM_CUT circuits-under-test (CUTs). For each CUT enabled in a mask, it does four things in order: resets the controller, issues a start, waits for bist_end and records the pass/fail result. A watchdog catches a controller that hangs. It sits between the top-level test port (go/cut_mask) and the single shared controller instance, so the controller is never driven by more than one session at a time.

---
 rtl/bist_pkg.sv | 24 ++
 rtl/bist_watchdog.sv | 28 ++
 rtl/bist_scheduler.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared constants and state encoding for the BIST scheduler and controller.
package bist_pkg;

    localparam int unsigned N_MAX       = 8;
    localparam int unsigned M_MAX       = 9;
    localparam int unsigned TIMEOUT_DEF = 200;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_CLR   = S_CLR,
        ST_START = S_START,
        ST_WAIT  = S_WAIT,
        ST_NEXT  = S_NEXT,
        ST_DONE  = S_DONE
    } state_t;

endpackage

// File: rtl/bist_watchdog.sv
// Per-CUT watchdog: counts WAIT cycles and flags the last allowed one.
module bist_watchdog #(
    parameter int unsigned TO_W    = 8,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    logic [TO_W-1:0] wdog;

    // Cycle counter, cleared at each controller start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog <= '0;
        end else if (clr) begin
            wdog <= '0;
        end else if (en) begin
            wdog <= wdog + TO_W'(1);
        end
    end

    assign expired_c = (wdog == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/bist_scheduler.sv
// Sequences the shared BIST controller over every CUT enabled in cut_mask.
module bist_scheduler
    import bist_pkg::*;
#(
    parameter int unsigned NUM_CUT = 4,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned TO_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic [NUM_CUT-1:0] cut_mask,
    input  logic               sig_ok,
    input  logic               ctrl_running,
    input  logic               ctrl_bist_end,
    output logic               ctrl_reset,
    output logic               ctrl_start,
    output logic [SEL_W-1:0]   cut_sel,
    output logic               busy,
    output logic               done,
    output logic [NUM_CUT-1:0] pass_vec,
    output logic               fail,
    output logic               timeout_err
);

    state_t             state;
    logic               go_q;
    logic [NUM_CUT-1:0] mask_q;
    logic               go_edge_c;
    logic               expired_c;
    logic [SEL_W-1:0]   first_sel_c;
    logic [SEL_W-1:0]   next_sel_c;
    logic               has_next_c;
    logic [NUM_CUT-1:0] pv_new_c;

    // Running flag is informational only; completion is taken from bist_end.
    logic unused_running;
    assign unused_running = ctrl_running;

    assign go_edge_c = go & ~go_q;

    bist_watchdog #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .reset     (reset),
        .clr       (state == ST_START),
        .en        (state == ST_WAIT),
        .expired_c (expired_c)
    );

    // Lowest set bit of the incoming mask, and next set bit above cut_sel.
    always_comb begin
        first_sel_c = '0;
        next_sel_c  = '0;
        has_next_c  = 1'b0;
        for (int i = int'(NUM_CUT) - 1; i >= 0; i--) begin
            if (cut_mask[i]) begin
                first_sel_c = SEL_W'(i);
            end
            if (mask_q[i] && (SEL_W'(i) > cut_sel)) begin
                next_sel_c = SEL_W'(i);
                has_next_c = 1'b1;
            end
        end
    end

    // Result vector with the current CUT's verdict merged in (timeout scores 0).
    always_comb begin
        pv_new_c          = pass_vec;
        pv_new_c[cut_sel] = ctrl_bist_end & sig_ok;
    end

    // Session FSM with registered controller handshake and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            go_q        <= 1'b0;
            mask_q      <= '0;
            ctrl_reset  <= 1'b1;
            ctrl_start  <= 1'b0;
            cut_sel     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass_vec    <= '0;
            fail        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            go_q       <= go;
            ctrl_start <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    ctrl_reset <= 1'b1;
                    if (go_edge_c) begin
                        mask_q      <= cut_mask;
                        pass_vec    <= '0;
                        fail        <= 1'b0;
                        timeout_err <= 1'b0;
                        if (|cut_mask) begin
                            cut_sel <= first_sel_c;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                            state   <= ST_CLR;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_CLR: begin
                    ctrl_reset <= 1'b1;
                    busy       <= 1'b1;
                    state      <= ST_START;
                end
                ST_START: begin
                    ctrl_reset <= 1'b0;
                    ctrl_start <= 1'b1;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ctrl_bist_end || expired_c) begin
                        pass_vec   <= pv_new_c;
                        fail       <= |(mask_q & ~pv_new_c);
                        ctrl_reset <= 1'b1;
                        state      <= ST_NEXT;
                        if (!ctrl_bist_end) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                ST_NEXT: begin
                    ctrl_reset <= 1'b1;
                    if (has_next_c) begin
                        cut_sel <= next_sel_c;
                        state   <= ST_CLR;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                default: begin
                    ctrl_reset <= 1'b1;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
